// File: rtl/lcd1602_seq.sv
// 4-bit HD44780-style LCD sequencer: timed power-up nibble init, then
// busy-flag polled byte writes over a wr/rd request + wrq wait handshake.
//
// state     | meaning
// PWRUP     | wait POWERUP_CYCLES after reset
// INIT_NIB  | write one init nibble (0x3, 0x3, 0x3, 0x2)
// INIT_WAIT | fixed NIB_WAIT_CYCLES delay after each init nibble
// INIT_CMD  | load the next init command byte
// IDLE      | ready for a user byte
// BF_HI     | read high nibble, capture busy flag
// BF_LO     | read low nibble (discarded)
// WR_HI     | write {rs, byte[7:4]}
// WR_LO     | write {rs, byte[3:0]}
module lcd1602_seq #(
    parameter int POWERUP_CYCLES  = 750000,
    parameter int NIB_WAIT_CYCLES = 205000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       init_done,
    output logic       wr,
    output logic       rd,
    output logic [4:0] wrd,
    input  logic [4:0] rdd,
    input  logic       wrq
);
    localparam int MAX_WAIT = (POWERUP_CYCLES > NIB_WAIT_CYCLES) ? POWERUP_CYCLES : NIB_WAIT_CYCLES;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] NIB_LAST = CW'(NIB_WAIT_CYCLES - 1);

    typedef enum logic [3:0] {
        PWRUP, INIT_NIB, INIT_WAIT, INIT_CMD, IDLE, BF_HI, BF_LO, WR_HI, WR_LO
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    nib_idx;
    logic [2:0]    cmd_idx;
    logic          lat_rs;
    logic [7:0]    lat_data;
    logic          bf;
    logic          unused_rdd;

    assign unused_rdd = ^{rdd[4], rdd[2:0]};

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    init_cmd = 8'h28;
            3'd1:    init_cmd = 8'h08;
            3'd2:    init_cmd = 8'h01;
            3'd3:    init_cmd = 8'h06;
            default: init_cmd = 8'h0C;
        endcase
    endfunction

    // Every request state enters with its request low, so a completion is
    // always followed by at least one idle cycle before the next request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PWRUP;
            cnt       <= '0;
            nib_idx   <= '0;
            cmd_idx   <= '0;
            lat_rs    <= 1'b0;
            lat_data  <= '0;
            bf        <= 1'b0;
            wr        <= 1'b0;
            rd        <= 1'b0;
            wrd       <= '0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                PWRUP: begin
                    if (cnt == PWR_LAST) begin
                        cnt   <= '0;
                        state <= INIT_NIB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_NIB: begin
                    if (!wr) begin
                        wr  <= 1'b1;
                        wrd <= {1'b0, (nib_idx == 2'd3) ? 4'h2 : 4'h3};
                    end else if (!wrq) begin
                        wr    <= 1'b0;
                        wrd   <= '0;
                        cnt   <= '0;
                        state <= INIT_WAIT;
                    end
                end
                INIT_WAIT: begin
                    if (cnt == NIB_LAST) begin
                        cnt <= '0;
                        if (nib_idx == 2'd3) begin
                            state <= INIT_CMD;
                        end else begin
                            nib_idx <= nib_idx + 1'b1;
                            state   <= INIT_NIB;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_CMD: begin
                    lat_rs   <= 1'b0;
                    lat_data <= init_cmd(cmd_idx);
                    state    <= BF_HI;
                end
                IDLE: begin
                    if (in_valid && in_ready) begin
                        lat_rs   <= in_rs;
                        lat_data <= in_data;
                        in_ready <= 1'b0;
                        state    <= BF_HI;
                    end
                end
                BF_HI: begin
                    if (!rd) begin
                        rd  <= 1'b1;
                        wrd <= '0;
                    end else if (!wrq) begin
                        rd    <= 1'b0;
                        bf    <= rdd[3];
                        state <= BF_LO;
                    end
                end
                BF_LO: begin
                    if (!rd) begin
                        rd <= 1'b1;
                    end else if (!wrq) begin
                        rd    <= 1'b0;
                        state <= bf ? BF_HI : WR_HI;
                    end
                end
                WR_HI: begin
                    if (!wr) begin
                        wr  <= 1'b1;
                        wrd <= {lat_rs, lat_data[7:4]};
                    end else if (!wrq) begin
                        wr    <= 1'b0;
                        wrd   <= '0;
                        state <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (!wr) begin
                        wr  <= 1'b1;
                        wrd <= {lat_rs, lat_data[3:0]};
                    end else if (!wrq) begin
                        wr  <= 1'b0;
                        wrd <= '0;
                        if (init_done) begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end else if (cmd_idx == 3'd4) begin
                            init_done <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cmd_idx <= cmd_idx + 1'b1;
                            state   <= INIT_CMD;
                        end
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd1602_seq.sv
// Bench for lcd1602_seq: an LCD controller model logs every completed request
// and the scenarios compare that log against transaction lists built from the byte-level rules.
module tb_lcd1602_seq;
    localparam int P = 20;
    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_rs;
    logic [7:0] in_data;
    logic       in_ready;
    logic       init_done;
    logic       wr;
    logic       rd;
    logic [4:0] wrd;
    logic [4:0] rdd;
    logic       wrq;

    always #5 clk = ~clk;

    lcd1602_seq #(.POWERUP_CYCLES(P), .NIB_WAIT_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
        .in_ready(in_ready), .init_done(init_done), .wr(wr), .rd(rd), .wrd(wrd),
        .rdd(rdd), .wrq(wrq)
    );

    typedef struct {
        bit         is_wr;
        logic [4:0] d;
        int         t_start;
        int         t_end;
    } xact_t;

    int    checks = 0;
    int    failures = 0;
    int    cyc;
    xact_t log_q[$];
    xact_t exp_q[$];

    // controller model state
    int proto_viol = 0;
    bit prev_req, prev_done, prev_wr;
    logic [4:0] prev_wrd;
    int req_start, hold_left, rd_count;
    int bf_busy_left = 0;
    int wait_fixed = 3;
    bit rand_wait = 0;
    bit stuck_wr = 0;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    always @(negedge clk) begin
        xact_t x;
        if (rst) begin
            prev_req = 0; prev_done = 0; rd_count = 0; hold_left = 0;
            wrq = 1'b0; rdd = 5'd0;
            log_q.delete();
        end else begin
            if (wr && rd) proto_viol++;
            if (rd && wrd !== 5'd0) proto_viol++;
            if (prev_done && (wr || rd)) proto_viol++;
            if (prev_req && !prev_done && (!(wr || rd) || wr !== prev_wr || wrd !== prev_wrd)) proto_viol++;
            rdd = 5'($urandom);
            if (wr || rd) begin
                if (!prev_req || prev_done) begin
                    req_start = cyc;
                    hold_left = rand_wait ? int'($urandom_range(0, 4)) : wait_fixed;
                end
                if ((stuck_wr && wr) || hold_left > 0) begin
                    wrq = 1'b1;
                    if (hold_left > 0) hold_left--;
                    prev_done = 0;
                end else begin
                    wrq = 1'b0;
                    prev_done = 1;
                    if (rd) begin
                        if (rd_count % 2 == 0) begin
                            if (bf_busy_left > 0) begin
                                rdd[3] = 1'b1;
                                bf_busy_left--;
                            end else begin
                                rdd[3] = 1'b0;
                            end
                        end
                        rd_count++;
                    end
                    x.is_wr = wr; x.d = wrd; x.t_start = req_start; x.t_end = cyc;
                    log_q.push_back(x);
                end
                prev_req = 1; prev_wr = wr; prev_wrd = wrd;
            end else begin
                wrq = 1'($urandom_range(0, 1));
                prev_req = 0; prev_done = 0;
            end
        end
    end

    // Reference: one byte = (busy+1) pairs of reads, then high and low nibble writes.
    function automatic void exp_byte(input bit rs, input logic [7:0] b, input int busy);
        xact_t x;
        x.t_start = 0; x.t_end = 0;
        for (int i = 0; i < 2 * (busy + 1); i++) begin
            x.is_wr = 0; x.d = 5'd0; exp_q.push_back(x);
        end
        x.is_wr = 1; x.d = {rs, b[7:4]}; exp_q.push_back(x);
        x.is_wr = 1; x.d = {rs, b[3:0]}; exp_q.push_back(x);
    endfunction

    function automatic void exp_init();
        logic [7:0] cmds [5] = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
        xact_t x;
        x.t_start = 0; x.t_end = 0; x.is_wr = 1;
        for (int i = 0; i < 4; i++) begin
            x.d = (i == 3) ? 5'h02 : 5'h03;
            exp_q.push_back(x);
        end
        for (int i = 0; i < 5; i++) exp_byte(0, cmds[i], 0);
    endfunction

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (in_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout in_ready=%b want=1 after %0d cycles", name, in_ready, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_rs = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr, rd, wrd, in_ready, init_done} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%09b want=000000000", {wr, rd, wrd, in_ready, init_done});
        end
    endtask

    task automatic test_init();
        int early = 0;
        int n = 0;
        logic [7:0] held = 8'($urandom);
        bit held_rs = 1'($urandom_range(0, 1));
        wait_fixed = 3; rand_wait = 0; bf_busy_left = 0;
        in_valid = 1'b1; in_rs = held_rs; in_data = held;
        rst = 1'b0;
        while (in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            if (in_ready === 1'b1 && init_done !== 1'b1) early++;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL init_done got ready=%b done=%b want 1/1", in_ready, init_done);
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL init_early_ready got=%0d want=0", early);
        end
        exp_q.delete();
        exp_init();
        checks++;
        if (log_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL init_count got=%0d want=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].is_wr !== exp_q[i].is_wr || log_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL init_xact[%0d] got=%0b/%02h want=%0b/%02h", i,
                         log_q[i].is_wr, log_q[i].d, exp_q[i].is_wr, exp_q[i].d);
            end
        end
        if (log_q.size() >= 4) begin
            checks++;
            if (log_q[0].t_start < P || log_q[0].t_start > P + 3) begin
                failures++;
                $display("FAIL powerup_delay got=%0d want=%0d..%0d", log_q[0].t_start, P, P + 3);
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (log_q[i].t_start - log_q[i-1].t_end < N) begin
                    failures++;
                    $display("FAIL nib_gap[%0d] got=%0d want>=%0d", i, log_q[i].t_start - log_q[i-1].t_end, N);
                end
            end
        end
        log_q.delete();
        exp_q.delete();
        exp_byte(held_rs, held, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL held_accept in_ready=%b want=0", in_ready);
        end
        wait_ready("held", 500);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL held_count got=%0d want=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].is_wr !== exp_q[i].is_wr || log_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL held_xact[%0d] got=%0b/%02h want=%0b/%02h", i,
                         log_q[i].is_wr, log_q[i].d, exp_q[i].is_wr, exp_q[i].d);
            end
        end
    endtask

    task automatic test_char();
        int low = 0;
        log_q.delete(); exp_q.delete();
        bf_busy_left = 0;
        exp_byte(1, 8'h41, 0);
        in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h41;
        @(negedge clk);
        in_valid = 1'b0;
        while (in_ready !== 1'b1 && low < 500) begin
            low++;
            @(negedge clk);
        end
        checks++;
        if (low < 10 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL char_ready_low got=%0d cycles low, ready=%b want>=10 and 1", low, in_ready);
        end
        checks++;
        if (log_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL char_count got=%0d want=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].is_wr !== exp_q[i].is_wr || log_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL char_xact[%0d] got=%0b/%02h want=%0b/%02h", i,
                         log_q[i].is_wr, log_q[i].d, exp_q[i].is_wr, exp_q[i].d);
            end
        end
    endtask

    task automatic test_bf_busy();
        logic [7:0] b = 8'($urandom);
        bit rs = 1'($urandom_range(0, 1));
        log_q.delete(); exp_q.delete();
        bf_busy_left = 3;
        exp_byte(rs, b, 3);
        in_valid = 1'b1; in_rs = rs; in_data = b;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ready("bf_busy", 800);
        checks++;
        if (log_q.size() != exp_q.size() || bf_busy_left != 0) begin
            failures++;
            $display("FAIL bf_busy_count got=%0d left=%0d want=%0d left=0", log_q.size(), bf_busy_left, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].is_wr !== exp_q[i].is_wr || log_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL bf_busy_xact[%0d] got=%0b/%02h want=%0b/%02h", i,
                         log_q[i].is_wr, log_q[i].d, exp_q[i].is_wr, exp_q[i].d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        log_q.delete(); exp_q.delete();
        rand_wait = 1;
        for (int k = 0; k < 10; k++) begin
            logic [7:0] b = 8'($urandom);
            bit rs = 1'($urandom_range(0, 1));
            int busy = int'($urandom_range(0, 2));
            n = 0;
            while (in_ready !== 1'b1 && n < 800) begin
                in_valid = 1'($urandom_range(0, 1));
                in_rs = 1'($urandom_range(0, 1));
                in_data = 8'($urandom);
                @(negedge clk);
                n++;
            end
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_timeout[%0d] in_ready=%b want=1", k, in_ready);
            end
            bf_busy_left = busy;
            exp_byte(rs, b, busy);
            in_valid = 1'b1; in_rs = rs; in_data = b;
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_ready("b2b_last", 800);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].is_wr !== exp_q[i].is_wr || log_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL b2b_xact[%0d] got=%0b/%02h want=%0b/%02h", i,
                         log_q[i].is_wr, log_q[i].d, exp_q[i].is_wr, exp_q[i].d);
            end
        end
        rand_wait = 0;
    endtask

    task automatic test_stall();
        logic [7:0] a = 8'($urandom);
        logic [7:0] b = 8'($urandom);
        bit rs = 1'($urandom_range(0, 1));
        int n = 0;
        int unstable = 0;
        log_q.delete(); exp_q.delete();
        bf_busy_left = 0;
        exp_byte(rs, a, 0);
        exp_byte(~rs, b, 0);
        stuck_wr = 1;
        in_valid = 1'b1; in_rs = rs; in_data = a;
        @(negedge clk);
        in_rs = ~rs; in_data = b;
        while (wr !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr !== 1'b1 || rd !== 1'b0 || wrd !== {rs, a[7:4]} || in_ready !== 1'b0) unstable++;
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL stall_stable got=%0d unstable cycles wrd=%02h want=0 wrd=%02h", unstable, wrd, {rs, a[7:4]});
        end
        stuck_wr = 0;
        wait_ready("stall_a", 500);
        @(negedge clk);
        in_valid = 1'b0;
        wait_ready("stall_b", 500);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL stall_count got=%0d want=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].is_wr !== exp_q[i].is_wr || log_q[i].d !== exp_q[i].d) begin
                failures++;
                $display("FAIL stall_xact[%0d] got=%0b/%02h want=%0b/%02h", i,
                         log_q[i].is_wr, log_q[i].d, exp_q[i].is_wr, exp_q[i].d);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'($urandom);
        int n = 0;
        b[3:0] = ~b[7:4];
        bf_busy_left = 0;
        in_valid = 1'b1; in_rs = 1'b1; in_data = b;
        @(negedge clk);
        in_valid = 1'b0;
        while (!(wr === 1'b1 && wrd === {1'b1, b[3:0]}) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr !== 1'b1 || wrd !== {1'b1, b[3:0]}) begin
            failures++;
            $display("FAIL rst_mid_reach wr=%b wrd=%02h want 1/%02h", wr, wrd, {1'b1, b[3:0]});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wr, rd, wrd, in_ready, init_done} !== 9'd0) begin
            failures++;
            $display("FAIL rst_async got=%09b want=000000000", {wr, rd, wrd, in_ready, init_done});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (log_q.size() < 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (log_q.size() < 4 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart got=%0d xacts done=%b want>=4 done=0", log_q.size(), init_done);
        end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].is_wr !== 1'b1 || log_q[i].d !== ((i == 3) ? 5'h02 : 5'h03)) begin
                failures++;
                $display("FAIL rst_nib[%0d] got=%0b/%02h want=1/%02h", i, log_q[i].is_wr, log_q[i].d,
                         (i == 3) ? 5'h02 : 5'h03);
            end
        end
        if (log_q.size() > 0) begin
            checks++;
            if (log_q[0].t_start < P || log_q[0].t_start > P + 3) begin
                failures++;
                $display("FAIL rst_powerup got=%0d want=%0d..%0d", log_q[0].t_start, P, P + 3);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rs = 1'b0; in_data = 8'h00;
        test_reset();
        test_init();
        test_char();
        test_bf_busy();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        checks++;
        if (proto_viol != 0) begin
            failures++;
            $display("FAIL protocol got=%0d violations want=0", proto_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
